// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared types and constants for the RV32I front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] pc_t;

    localparam int unsigned INST_BYTES = 4;
    localparam word_t       NOP_INST   = 32'h0000_0013;

    typedef struct packed {
        pc_t   pc;
        word_t inst;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
// ============================================================================
// Module      : fetch_skid_buffer
// Description : 2-deep FIFO of fetched {pc, inst} entries with flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_skid_buffer
    import core_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    fetch_entry_t r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign full  = (r_count == 2'd2);
    assign empty = (r_count == 2'd0);

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module      : instruction_fetch
// Description : PC owner and ROM fetch initiator feeding decode over
//               valid/ready. Define FETCH_SKID_EN for the 2-entry skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch
    import core_pkg::*;
#(
    parameter pc_t RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_r_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    pc_t          r_pc;
    logic         r_resp_valid;
    pc_t          r_resp_pc;
    logic         r_inst_valid;
    word_t        r_inst_data;
    pc_t          r_inst_pc;

    logic         w_out_free;
    logic         w_issue;
    logic         w_load;
    logic         w_pc_update;
    pc_t          w_pc_next;
    fetch_entry_t w_resp_entry;
    fetch_entry_t w_load_entry;
    logic [1:0]   w_unused_redirect_bits;

    assign w_unused_redirect_bits = redirect_pc[1:0];
    assign w_out_free   = !r_inst_valid || inst_ready;
    assign w_resp_entry = '{pc: r_resp_pc, inst: rom_r_data};
    assign rom_addr     = {2'b00, r_pc[31:2]};

`ifdef FETCH_SKID_EN
    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    logic         w_fill_next;
    fetch_entry_t w_head;

    assign w_pop  = w_out_free && !w_empty;
    assign w_push = r_resp_valid && !(w_out_free && w_empty);
    // Hold issue when the buffer ends this edge full, so the next response always fits.
    assign w_fill_next  = (w_full && !w_pop) || (!w_full && !w_empty && w_push && !w_pop);
    assign w_issue      = !w_fill_next;
    assign w_load       = w_out_free && (!w_empty || r_resp_valid);
    assign w_load_entry = w_empty ? w_resp_entry : w_head;
    assign w_pc_update  = w_issue;
    assign w_pc_next    = r_pc + pc_t'(INST_BYTES);

    fetch_skid_buffer u_skid (
        .clock      (clock),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (w_push),
        .push_entry (w_resp_entry),
        .pop        (w_pop),
        .head       (w_head),
        .full       (w_full),
        .empty      (w_empty)
    );
`else
    assign w_issue      = w_out_free;
    assign w_load       = w_out_free && r_resp_valid;
    assign w_load_entry = w_resp_entry;
    // A response that cannot be presented is dropped and its address replayed.
    assign w_pc_update  = w_issue || r_resp_valid;
    assign w_pc_next    = (r_resp_valid && !w_out_free) ? r_resp_pc
                                                        : r_pc + pc_t'(INST_BYTES);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_resp_valid <= 1'b0;
            r_resp_pc    <= '0;
            r_inst_valid <= 1'b0;
            r_inst_data  <= '0;
            r_inst_pc    <= '0;
        end else if (redirect_valid) begin
            r_pc         <= {redirect_pc[31:2], 2'b00};
            r_resp_valid <= 1'b0;
            r_inst_valid <= 1'b0;
        end else begin
            if (w_pc_update) begin
                r_pc <= w_pc_next;
            end
            r_resp_valid <= w_issue;
            if (w_issue) begin
                r_resp_pc <= r_pc;
            end
            if (w_out_free) begin
                r_inst_valid <= w_load;
                if (w_load) begin
                    r_inst_data <= w_load_entry.inst;
                    r_inst_pc   <= w_load_entry.pc;
                end
            end
        end
    end

    assign inst_valid = r_inst_valid;
    assign inst_data  = r_inst_data;
    assign inst_pc    = r_inst_pc;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Self-checking bench for instruction_fetch (both build modes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] rom_addr, rom_r_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data, inst_pc;

    logic [31:0] wrom_addr, wrom_r_data;
    logic        wredirect_valid;
    logic [31:0] wredirect_pc;
    logic        winst_valid, winst_ready;
    logic [31:0] winst_data, winst_pc;

    int          checks = 0;
    int          errors = 0;
    int          n_xfer = 0;
    int          since  = 0;
    logic [31:0] exp_pc;
    logic [31:0] wexp_pc;
    logic        stalled_prev = 1'b0;
    logic        bubble_next  = 1'b0;

    always #5 clock = ~clock;

    // ROM contents: word n holds n
    always @(posedge clock) begin
        rom_r_data  <= rom_addr;
        wrom_r_data <= wrom_addr;
    end

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clock(clock), .reset(reset), .rom_addr(rom_addr), .rom_r_data(rom_r_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
    );

    instruction_fetch #(.RESET_PC(WRAP_PC)) dut_wrap (
        .clock(clock), .reset(reset), .rom_addr(wrom_addr), .rom_r_data(wrom_r_data),
        .redirect_valid(wredirect_valid), .redirect_pc(wredirect_pc),
        .inst_valid(winst_valid), .inst_ready(winst_ready),
        .inst_data(winst_data), .inst_pc(winst_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: handshake checks before the edge, model update and checks after it.
    task automatic step();
        logic        pv, pr, prd, prst, rel;
        logic [31:0] ppc, pdat, prpc;
        pv   = inst_valid;
        pr   = inst_ready;
        ppc  = inst_pc;
        pdat = inst_data;
        prd  = redirect_valid;
        prpc = redirect_pc;
        prst = reset;
        rel  = pv && pr && stalled_prev;
        if (!prst && pv && pr) begin
            chk("xfer_pc", ppc, exp_pc);
            chk("xfer_data", pdat, ppc >> 2);
            exp_pc = exp_pc + 32'd4;
            n_xfer++;
        end
        if (!prst && winst_valid) begin
            chk("wrap_pc", winst_pc, wexp_pc);
            chk("wrap_data", winst_data, winst_pc >> 2);
            wexp_pc = wexp_pc + 32'd4;
        end
        @(posedge clock);
        #1;
        if (prst) begin
            exp_pc      = 32'h0;
            wexp_pc     = WRAP_PC;
            since       = 0;
            bubble_next = 1'b0;
            chk("reset_valid", {31'b0, inst_valid}, 32'd0);
            chk("reset_rom_addr", rom_addr, 32'h0);
            chk("reset_wrap_rom_addr", wrom_addr, WRAP_PC >> 2);
        end else if (prd) begin
            exp_pc      = {prpc[31:2], 2'b00};
            since       = 0;
            bubble_next = 1'b0;
            chk("redirect_valid_drop", {31'b0, inst_valid}, 32'd0);
            chk("redirect_rom_addr", rom_addr, prpc >> 2);
        end else begin
            since++;
            if (since == 1) chk("restart_lat1", {31'b0, inst_valid}, 32'd0);
            if (since == 2) chk("restart_lat2", {31'b0, inst_valid}, 32'd1);
            if (pv && !pr) begin
                chk("hold_valid", {31'b0, inst_valid}, 32'd1);
                chk("hold_pc", inst_pc, ppc);
                chk("hold_data", inst_data, pdat);
            end
            if (rel) begin
`ifdef FETCH_SKID_EN
                chk("release_no_bubble", {31'b0, inst_valid}, 32'd1);
`else
                chk("release_bubble", {31'b0, inst_valid}, 32'd0);
                bubble_next = 1'b1;
`endif
            end else if (bubble_next) begin
                chk("after_bubble", {31'b0, inst_valid}, 32'd1);
                bubble_next = 1'b0;
            end
        end
        stalled_prev = !prst && !prd && pv && !pr;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!inst_valid && n < 6) begin
            step();
            n++;
        end
        chk(tag, {31'b0, inst_valid}, 32'd1);
    endtask

    initial begin
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        inst_ready      = 1'b1;
        wredirect_valid = 1'b0;
        wredirect_pc    = 32'h0;
        winst_ready     = 1'b1;
        exp_pc          = 32'h0;
        wexp_pc         = WRAP_PC;

        // Reset and free-running fetch from 0; wrap instance crosses 0xFFFF_FFFC -> 0
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t1_rom_addr", rom_addr, i + 1);
            if (i == 3) chk("t5_wrap_to_zero", winst_pc, 32'h0);
        end
        chk("t1_pc_0x10", inst_pc, 32'h10);

        // Stall for 5 cycles on 0x10, then release
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("t2_hold_pc", inst_pc, 32'h10);
        chk("t2_hold_data", inst_data, 32'd4);
        inst_ready = 1'b1;
        step();
        wait_valid("t2_resume_valid");
        chk("t2_resume_pc", inst_pc, 32'h14);

        // Redirect to 0x40 while 0x08 is presented
        do_reset();
        for (int i = 0; i < 4; i++) step();
        chk("t3_pc_0x08", inst_pc, 32'h08);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        chk("t3_first_pc", inst_pc, 32'h40);
        chk("t3_first_data", inst_data, 32'd16);

        // Redirect to 0x43 during a stall
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        step();
        chk("t4_rom_addr", rom_addr, 32'h10);
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        step();
        step();
        chk("t4_first_pc", inst_pc, 32'h40);

        // Reset pulse mid-stream while stalled, then restart as from power-up
        inst_ready = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset      = 1'b0;
        inst_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t6_rom_addr", rom_addr, i + 1);
        end

        // Randomised traffic against the ordering model
        for (int i = 0; i < 400; i++) begin
            inst_ready     = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom_range(0, 1023);
            reset          = ($urandom_range(0, 149) == 0);
            step();
        end
        reset          = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("progress", {31'b0, (n_xfer >= 80)}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
